// File: rtl/ttl_bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter:
// FSM state encoding, master index names and small helpers.
package ttl_bus_arbiter_pkg;

    localparam int MAX_NREQ = 8;

    // Fixed master slots on the system bus
    localparam int M_CPU   = 0;
    localparam int M_DMA   = 1;
    localparam int M_VID   = 2;
    localparam int M_PANEL = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REL   = 2'd2
    } state_t;

    // Index of the next master after idx, wrapping n-1 -> 0
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ttl_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr,
// scanning upward and wrapping modulo NREQ.
module ttl_bus_arbiter_rr_pick
    import ttl_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    // Scan from the farthest offset down so the nearest hit wins
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/ttl_bus_arbiter.sv
// Round-robin system bus arbiter with registered one-hot grants,
// a dead turnaround cycle between owners and a hold watchdog.
module ttl_bus_arbiter
    import ttl_bus_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rd,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            bus_busy,
    output logic            timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [7:0]     hold_cnt;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           owner_rel;
    logic           expire;
    logic [IDW-1:0] next_ptr;

    ttl_bus_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Owner status: explicit release, dropped request, or watchdog
    always_comb begin
        owner_rel = done[gnt_id] | ~req[gnt_id];
        expire    = (hold_cnt == HOLD_LAST);
        next_ptr  = IDW'(wrap_inc(int'(gnt_id), NREQ));
    end

    // Arbitration FSM with registered grant, id, busy and timeout
    always_ff @(posedge clk) begin
        if (!rd) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt      <= NREQ'(1) << pick_idx;
                        gnt_id   <= pick_idx;
                        bus_busy <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                    if (owner_rel || expire) begin
                        gnt      <= '0;
                        bus_busy <= 1'b0;
                        ptr      <= next_ptr;
                        timeout  <= ~owner_rel;
                        state    <= ST_REL;
                    end
                end
                ST_REL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

    gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));

endmodule
